// File: rtl/multicycle_control.sv
// Control sequencer for the shared multi-cycle RV32I datapath (R-type, load, store, BEQ/BNE).
// Outputs decode from the current state; only FETCH/MEM_WR/BRANCH look at mem_ready or zero.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       w_opc;
  logic             w_legal;

  assign w_opc   = instr[6:2];
  assign w_legal = (instr[1:0] == 2'b11);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:      w_next = S_FETCH;
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next = S_TRAP;
        if (w_legal) begin
          case (w_opc)
            5'b01100:          w_next = S_EXEC_R;
            5'b00000, 5'b01000: w_next = S_MEM_ADDR;
            // only funct3 000 (BEQ) and 001 (BNE) are branches we execute
            5'b11000:          w_next = (instr[14:13] == 2'b00) ? S_BRANCH : S_TRAP;
            default:           w_next = S_TRAP;
          endcase
        end
      end
      S_EXEC_R:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = (w_opc == 5'b00000) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ALUOp      = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b10;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOp     = 2'b10;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUOp     = 2'b01;
        pc_src    = 1'b1;
        retire    = 1'b1;
        // instr[12] distinguishes BNE (taken on non-zero) from BEQ
        pc_write  = zero ^ instr[12];
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RST;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (retire) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retired_count = r_count;
  assign state         = r_state;

endmodule
